// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory read port, redirect input and decode handshake.
// The master modport is the fetch unit; the slave modport is its environment.
interface fetch_unit_if #(
    parameter int ADDR_W = 8
);
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              valid_out;
    logic              ready_in;
    logic [31:0]       inst_out;
    logic [31:0]       pc_out;

    modport master (
        output imem_en, imem_addr, valid_out, inst_out, pc_out,
        input  imem_rdata, redirect_valid, redirect_pc, ready_in
    );

    modport slave (
        input  imem_en, imem_addr, valid_out, inst_out, pc_out,
        output imem_rdata, redirect_valid, redirect_pc, ready_in
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, hides the 1-cycle imem latency behind a
// 2-entry {inst,pc} buffer, and flushes on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] pc_q, pc_d;
    logic        infl_q, infl_d;
    logic [31:0] infl_pc_q, infl_pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] inst_q [2];
    logic [31:0] inst_d [2];
    logic [31:0] pcb_q [2];
    logic [31:0] pcb_d [2];

    logic        valid;
    logic        pop;
    logic        issue;
    logic [2:0]  cnt_next;
    logic [1:0]  wr_idx;

    assign valid = (cnt_q != 2'd0);

    assign bus.valid_out = valid;
    assign bus.inst_out  = valid ? inst_q[0] : NOP;
    assign bus.pc_out    = valid ? pcb_q[0]  : 32'h0;
    assign bus.imem_en   = issue;
    assign bus.imem_addr = pc_q[ADDR_W+1:2];

    // Issue only if the word coming back next cycle is guaranteed a free slot.
    always_comb begin
        pop      = valid && bus.ready_in && !bus.redirect_valid;
        cnt_next = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
        issue    = rst_n && !bus.redirect_valid && (cnt_next <= 3'd1);
        wr_idx   = cnt_q - {1'b0, pop};
    end

    always_comb begin
        pc_d      = pc_q;
        infl_d    = issue;
        infl_pc_d = infl_pc_q;
        cnt_d     = cnt_next[1:0];
        inst_d    = inst_q;
        pcb_d     = pcb_q;

        if (pop) begin
            inst_d[0] = inst_q[1];
            pcb_d[0]  = pcb_q[1];
        end
        // Write slot is computed after the pop shift, so it lands behind the survivor.
        if (infl_q) begin
            inst_d[wr_idx[0]] = bus.imem_rdata;
            pcb_d[wr_idx[0]]  = infl_pc_q;
        end
        if (issue) begin
            infl_pc_d = pc_q;
            pc_d      = pc_q + 32'd4;
        end
        if (bus.redirect_valid) begin
            cnt_d  = 2'd0;
            infl_d = 1'b0;
            pc_d   = {bus.redirect_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= 32'h0;
            cnt_q     <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                inst_q[i] <= 32'h0;
                pcb_q[i]  <= 32'h0;
            end
        end else begin
            assert (cnt_next <= 3'd2);
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
            cnt_q     <= cnt_d;
            for (int i = 0; i < 2; i++) begin
                inst_q[i] <= inst_d[i];
                pcb_q[i]  <= pcb_d[i];
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (default and wrapping RESET_PC), each
// fed by a synchronous memory whose word i holds the value i.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   errors  = 0;

    logic [31:0] mem [256];

    fetch_unit_if #(.ADDR_W(8)) bus_a ();
    fetch_unit_if #(.ADDR_W(8)) bus_b ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.master)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .ADDR_W(8)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_a.imem_en) bus_a.imem_rdata <= mem[bus_a.imem_addr];
        if (bus_b.imem_en) bus_b.imem_rdata <= mem[bus_b.imem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, ".valid"}, {31'b0, bus_a.valid_out}, {31'b0, v});
        chk({tag, ".pc"},    bus_a.pc_out,   pc);
        chk({tag, ".inst"},  bus_a.inst_out, inst);
    endtask

    task automatic chk_fa(input string tag, input logic en, input logic [7:0] addr);
        chk({tag, ".en"}, {31'b0, bus_a.imem_en}, {31'b0, en});
        if (en) chk({tag, ".addr"}, {24'b0, bus_a.imem_addr}, {24'b0, addr});
    endtask

    task automatic chk_b(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, ".valid"}, {31'b0, bus_b.valid_out}, 32'd1);
        chk({tag, ".pc"},    bus_b.pc_out,   pc);
        chk({tag, ".inst"},  bus_b.inst_out, inst);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = i;
        rst_n                = 1'b0;
        bus_a.ready_in       = 1'b1;
        bus_a.redirect_valid = 1'b0;
        bus_a.redirect_pc    = 32'h0;
        bus_a.imem_rdata     = 32'h0;
        bus_b.ready_in       = 1'b1;
        bus_b.redirect_valid = 1'b0;
        bus_b.redirect_pc    = 32'h0;
        bus_b.imem_rdata     = 32'h0;

        #12;
        chk_a("rst", 1'b0, 32'h0, 32'h13);
        chk("rst.en",   {31'b0, bus_a.imem_en}, 32'd0);
        chk("rst.addr", {24'b0, bus_a.imem_addr}, 32'd0);
        chk("rst_b.addr", {24'b0, bus_b.imem_addr}, 32'hFE);

        // Reset release, free-running stream.
        rst_n = 1'b1;
        #1;
        chk_fa("c0", 1'b1, 8'h00);
        chk_a("c0", 1'b0, 32'h0, 32'h13);
        chk("c0_b.addr", {24'b0, bus_b.imem_addr}, 32'hFE);
        tick(); #1;
        chk_fa("c1", 1'b1, 8'h01);
        chk_a("c1", 1'b0, 32'h0, 32'h13);
        tick(); #1;
        chk_a("c2", 1'b1, 32'h0, 32'h0);
        chk_fa("c2", 1'b1, 8'h02);
        chk_b("c2_b", 32'hFFFF_FFF8, 32'hFE);
        tick(); #1;
        chk_a("c3", 1'b1, 32'h4, 32'h1);
        chk_b("c3_b", 32'hFFFF_FFFC, 32'hFF);
        tick(); #1;
        chk_a("c4", 1'b1, 32'h8, 32'h2);
        chk_b("c4_b", 32'h0000_0000, 32'h0);

        // Stall for four cycles.
        tick(); bus_a.ready_in = 1'b0; #1;
        chk_a("c5", 1'b1, 32'hC, 32'h3);
        chk_b("c5_b", 32'h0000_0004, 32'h1);
        chk_fa("c5", 1'b0, 8'h00);
        for (int c = 6; c <= 8; c++) begin
            tick(); #1;
            chk_a("stall", 1'b1, 32'hC, 32'h3);
            chk_fa("stall", 1'b0, 8'h00);
        end
        tick(); bus_a.ready_in = 1'b1; #1;
        chk_a("c9", 1'b1, 32'hC, 32'h3);
        chk_fa("c9", 1'b1, 8'h05);
        tick(); #1;
        chk_a("c10", 1'b1, 32'h10, 32'h4);
        chk_fa("c10", 1'b1, 8'h06);
        tick(); #1;
        chk_a("c11", 1'b1, 32'h14, 32'h5);

        // Redirect with an outstanding read that must be dropped.
        tick(); bus_a.redirect_valid = 1'b1; bus_a.redirect_pc = 32'h0000_0043; #1;
        chk_a("c12", 1'b1, 32'h18, 32'h6);
        chk_fa("c12", 1'b0, 8'h00);
        tick(); bus_a.redirect_valid = 1'b0; #1;
        chk_a("c13", 1'b0, 32'h0, 32'h13);
        chk_fa("c13", 1'b1, 8'h10);
        tick(); #1;
        chk_a("c14", 1'b0, 32'h0, 32'h13);
        chk_fa("c14", 1'b1, 8'h11);
        tick(); #1;
        chk_a("c15", 1'b1, 32'h40, 32'h10);
        tick(); #1;
        chk_a("c16", 1'b1, 32'h44, 32'h11);

        // Fill the buffer, then back-to-back redirects while stalled.
        tick(); bus_a.ready_in = 1'b0; #1;
        chk_a("c17", 1'b1, 32'h48, 32'h12);
        chk_fa("c17", 1'b0, 8'h00);
        tick(); bus_a.redirect_valid = 1'b1; bus_a.redirect_pc = 32'h0000_0300; #1;
        chk_a("c18", 1'b1, 32'h48, 32'h12);
        chk_fa("c18", 1'b0, 8'h00);
        tick(); bus_a.redirect_pc = 32'h0000_0082; #1;
        chk_a("c19", 1'b0, 32'h0, 32'h13);
        chk_fa("c19", 1'b0, 8'h00);
        tick(); bus_a.redirect_valid = 1'b0; #1;
        chk_a("c20", 1'b0, 32'h0, 32'h13);
        chk_fa("c20", 1'b1, 8'h20);
        tick(); #1;
        chk_a("c21", 1'b0, 32'h0, 32'h13);
        chk_fa("c21", 1'b1, 8'h21);
        tick(); #1;
        chk_a("c22", 1'b1, 32'h80, 32'h20);
        chk_fa("c22", 1'b0, 8'h00);
        tick(); #1;
        chk_a("c23", 1'b1, 32'h80, 32'h20);
        tick(); bus_a.ready_in = 1'b1; #1;
        chk_a("c24", 1'b1, 32'h80, 32'h20);
        chk_fa("c24", 1'b1, 8'h22);
        tick(); #1;
        chk_a("c25", 1'b1, 32'h84, 32'h21);
        tick(); #1;
        chk_a("c26", 1'b1, 32'h88, 32'h22);

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1;
        chk_a("arst", 1'b0, 32'h0, 32'h13);
        chk("arst.en",   {31'b0, bus_a.imem_en}, 32'd0);
        chk("arst.addr", {24'b0, bus_a.imem_addr}, 32'd0);
        tick(); #1;
        chk_a("arst_hold", 1'b0, 32'h0, 32'h13);
        rst_n = 1'b1;
        #1;
        chk_fa("r0", 1'b1, 8'h00);
        tick(); #1;
        chk_a("r1", 1'b0, 32'h0, 32'h13);
        chk_fa("r1", 1'b1, 8'h01);
        tick(); #1;
        chk_a("r2", 1'b1, 32'h0, 32'h0);
        tick(); #1;
        chk_a("r3", 1'b1, 32'h4, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
